// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with occupancy/threshold flags, sticky error flags
// and a choice of registered (latency-1) or first-word-fall-through read data.
module fifo_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int AFULL_TH  = (2**ADDR_W) - 2,
   parameter int AEMPTY_TH = 2,
   parameter bit FWFT      = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int                 DEPTH    = 2**ADDR_W;
   localparam int                 CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   AFULL_C  = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0]   AEMPTY_C = CNT_W'(AEMPTY_TH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wr_acc, rd_acc;

   // Flags come only from the registered count, so no input reaches them combinationally.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_acc = wr_en & ~full  & ~clr;
   assign rd_acc = rd_en & ~empty & ~clr;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         overflow_d  = overflow_q  | (wr_en & full);
         underflow_d = underflow_q | (rd_en & empty);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: storage is deliberately not reset; zeroed pointers and count keep stale words unreachable.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= din;
   end

   if (FWFT == 1'b0) begin : g_std
      logic [DATA_W-1:0] dout_q, dout_d;

      always_comb begin
         dout_d = dout_q;
         if (clr)         dout_d = '0;
         else if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) dout_q <= '0;
         else        dout_q <= dout_d;
      end

      assign dout = dout_q;
   end else begin : g_fwft
      // Head word is shown while data is present; zero when empty matches reset/clr behaviour.
      assign dout = empty ? '0 : mem_q[rd_ptr_q];
   end

endmodule
